// File: rtl/spi_tx_feeder.sv
// TX FIFO plus load sequencer in front of an SPI master's parallel load port.
// Optional sticky overflow flag is enabled by defining SPI_TXF_OVF_EN.
module spi_tx_feeder #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int GAP_CYC = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic                     i_spi_busy,
    input  logic                     i_spi_done,
    output logic [WIDTH-1:0]         o_PDATA,
    output logic                     o_valid,
    input  logic                     i_ovf_clr,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             ready_q;
    logic [GW-1:0]    gap_cnt_q;
    logic             wr_ok;
    logic             pop;

    // ready_q samples "data present and master idle" one edge ahead of the load,
    // so a fresh word loads on the second edge after its write edge.
    always_comb begin
        wr_ok    = i_wr_en && !full_q;
        pop      = (state_q == IDLE) && ready_q && !empty_q && !i_spi_busy;
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            empty_q  <= (count_d == '0);
            ready_q  <= !empty_q && !i_spi_busy;
        end
    end

    // NOTE: storage has no reset; stale contents are unreachable once count is 0.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    // Done is checked before busy so a frame that ends inside the handshake
    // cannot strand the sequencer waiting for a second done.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            o_valid   <= 1'b0;
            o_PDATA   <= '0;
            gap_cnt_q <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        o_PDATA <= mem_q[rd_ptr_q];
                        o_valid <= 1'b1;
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (i_spi_done) begin
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end else if (i_spi_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_spi_done) begin
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_count = count_q;

`ifdef SPI_TXF_OVF_EN
    logic ovf_q;

    // A new overflow in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (i_wr_en && full_q) begin
            ovf_q <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign o_ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = i_ovf_clr;
    assign o_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed testbench for spi_tx_feeder: reset, single load, fill/overflow,
// inter-frame gap timing, simultaneous write+pop and reset mid-frame.
module tb_spi_tx_feeder;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int GAP_CYC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] pdata;
    logic             valid;
    logic             ovf_clr;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_tx_feeder #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .o_full     (full),
        .o_empty    (empty),
        .o_count    (count),
        .i_spi_busy (busy),
        .i_spi_done (done),
        .o_PDATA    (pdata),
        .o_valid    (valid),
        .i_ovf_clr  (ovf_clr),
        .o_ovf      (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_edges, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_edges && !found; i++) begin
            tick();
            if (valid) found = 1'b1;
        end
    endtask

    task automatic do_frame(input logic [WIDTH-1:0] exp, input string tag);
        bit found;
        wait_valid(20, found);
        check({tag, "_seen"}, 32'(found), 32'd1);
        check({tag, "_data"}, 32'(pdata), 32'(exp));
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic count_valids(input int n_edges, output int n_seen);
        n_seen = 0;
        for (int i = 0; i < n_edges; i++) begin
            tick();
            if (valid) n_seen++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int n_seen;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        busy    = 1'b0;
        done    = 1'b0;
        ovf_clr = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pdata", 32'(pdata), 32'h00);
        check("rst_ovf",   32'(ovf),   32'd0);
        rst = 1'b0;
        tick();

        // Single word: load strobe on the second edge after the write edge
        wr_en   = 1'b1;
        wr_data = 8'h8D;
        tick();
        wr_en = 1'b0;
        check("single_count_w", 32'(count), 32'd1);
        check("single_empty_w", 32'(empty), 32'd0);
        check("single_valid_w", 32'(valid), 32'd0);
        tick();
        check("single_valid_w1", 32'(valid), 32'd0);
        tick();
        check("single_valid_w2", 32'(valid), 32'd1);
        check("single_pdata",    32'(pdata), 32'h8D);
        check("single_count_0",  32'(count), 32'd0);
        check("single_empty_1",  32'(empty), 32'd1);
        tick();
        check("single_valid_w3", 32'(valid), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        // done pulse in IDLE must be ignored
        done = 1'b1;
        tick();
        done = 1'b0;
        count_valids(5, n_seen);
        check("single_no_extra", 32'(n_seen), 32'd0);
        check("single_pdata_hold", 32'(pdata), 32'h8D);

        // Fill while the master is busy, then overflow
        busy = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("fill_count", 32'(count), 32'd8);
        check("fill_full",  32'(full),  32'd1);
        check("fill_empty", 32'(empty), 32'd0);
        check("fill_valid", 32'(valid), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'hDF;
        tick();
        wr_en = 1'b0;
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_full",  32'(full),  32'd1);
`ifdef SPI_TXF_OVF_EN
        check("ovf_set", 32'(ovf), 32'd1);
        tick();
        check("ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        wr_en   = 1'b1;
        ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0;
        check("ovf_set_wins", 32'(ovf), 32'd1);
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared2", 32'(ovf), 32'd0);
`else
        check("ovf_tied_low", 32'(ovf), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_still_low", 32'(ovf), 32'd0);
`endif
        busy = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            do_frame(8'(i), $sformatf("drain%0d", i));
        end
        count_valids(10, n_seen);
        check("drain_no_extra", 32'(n_seen), 32'd0);
        check("drain_count",    32'(count),  32'd0);
        check("drain_empty",    32'(empty),  32'd1);
        check("drain_full",     32'(full),   32'd0);

        // Frame sequence with the inter-frame gap
        wr_en   = 1'b1;
        wr_data = 8'hDB;
        tick();
        wr_data = 8'hDF;
        tick();
        wr_en = 1'b0;
        check("seq_valid_early", 32'(valid), 32'd0);
        tick();
        check("seq_valid1", 32'(valid), 32'd1);
        check("seq_pdata1", 32'(pdata), 32'hDB);
        check("seq_count1", 32'(count), 32'd1);
        tick();
        check("seq_valid1_off", 32'(valid), 32'd0);
        busy = 1'b1;
        count_valids(80, n_seen);
        check("seq_busy_quiet", 32'(n_seen), 32'd0);
        done = 1'b1;
        busy = 1'b0;
        tick();
        done = 1'b0;
        check("seq_gap_e0", 32'(valid), 32'd0);
        tick();
        check("seq_gap_e1", 32'(valid), 32'd0);
        tick();
        check("seq_gap_e2", 32'(valid), 32'd0);
        tick();
        check("seq_valid2", 32'(valid), 32'd1);
        check("seq_pdata2", 32'(pdata), 32'hDF);
        check("seq_count2", 32'(count), 32'd0);
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        tick();

        // Simultaneous write and pop keeps the count and the order
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'hA1 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        busy  = 1'b0;
        wait_valid(10, found);
        check("sim_first_seen", 32'(found), 32'd1);
        check("sim_first_data", 32'(pdata), 32'hA1);
        check("sim_first_cnt",  32'(count), 32'd3);
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("sim_valid", 32'(valid), 32'd1);
        check("sim_pdata", 32'(pdata), 32'hA2);
        check("sim_count", 32'(count), 32'd3);
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        do_frame(8'hA3, "sim_a3");
        do_frame(8'hA4, "sim_a4");
        do_frame(8'hA5, "sim_a5");
        tick();
        tick();
        tick();
        check("sim_end_count", 32'(count), 32'd0);
        check("sim_end_empty", 32'(empty), 32'd1);

        // Reset in the middle of a frame
        wr_en   = 1'b1;
        wr_data = 8'hB1;
        tick();
        wr_data = 8'hB2;
        tick();
        wr_en = 1'b0;
        wait_valid(10, found);
        check("mid_seen", 32'(found), 32'd1);
        check("mid_data", 32'(pdata), 32'hB1);
        busy = 1'b1;
        tick();
        tick();
        check("mid_count_pre", 32'(count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full",  32'(full),  32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_pdata", 32'(pdata), 32'h00);
        tick();
        rst  = 1'b0;
        busy = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        count_valids(10, n_seen);
        check("mid_no_valid",  32'(n_seen), 32'd0);
        check("mid_count_end", 32'(count),  32'd0);
        wr_en   = 1'b1;
        wr_data = 8'hC3;
        tick();
        wr_en = 1'b0;
        tick();
        check("post_rst_valid_w1", 32'(valid), 32'd0);
        tick();
        check("post_rst_valid_w2", 32'(valid), 32'd1);
        check("post_rst_pdata",    32'(pdata), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
